stack_unit: RTL and testbench
=============================

Name: stack_unit

Overview:
- Hardware LIFO operand stack for the stack-machine CPU; sits directly downstream of the CPU control FSM.
- Consumes the control's push/pop strobes and pushed byte; produces the top-of-stack byte the FSM loads into the ALU temp registers.
- Also exposes next-on-stack, the popped value with a valid pulse, depth, and sticky overflow/underflow error flags.

Parameters:
- DATA_W, 8, width of each stack entry.
- DEPTH, 16, number of entries; power of two, >= 2.
- PTR_W, 4, log2(DEPTH); count is PTR_W+1 bits.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  push strobe, sampled each rising edge.
- pop  in  1  pop strobe, sampled each rising edge.
- data_in  in  DATA_W  value to push.
- clr_err  in  1  clears the sticky overflow/underflow flags.
- tos  out  DATA_W  current top-of-stack; 0 when empty.
- nos  out  DATA_W  entry below top; 0 when count < 2.
- pop_data  out  DATA_W  value removed by the last accepted pop.
- pop_valid  out  1  one-cycle pulse, pop_data updated this cycle.
- count  out  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a push was rejected while full.
- underflow  out  1  sticky: a pop was issued while empty.

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- All outputs are registered. An operation sampled at edge N is visible on every output after edge N.
- Reset (dominates all inputs):
  - count=0, tos=0, nos=0, pop_data=0, pop_valid=0, overflow=0, underflow=0, empty=1, full=0.
  - Storage contents are don't-care.
  - Reset asserted mid-sequence discards every entry.
- Operation decode per edge, in priority order:
  - IDLE (push=0, pop=0): state held; pop_valid=0.
  - PUSH (push=1, pop=0, !full): mem[count] <= data_in; count+1; tos <= data_in; nos <= old tos.
  - PUSH when full: ignored. Storage, count, tos and nos unchanged; overflow <= 1.
  - POP (push=0, pop=1, count>0): pop_data <= old tos; pop_valid <= 1; count-1; tos <= old nos; nos <= mem[count-3] if count>=3, else 0.
  - POP when empty: no state change; pop_valid=0; pop_data held; underflow <= 1.
  - REPLACE (push=1, pop=1, count>0): top entry overwritten with data_in; count unchanged; pop_data <= old tos; pop_valid <= 1; tos <= data_in; nos unchanged. Legal when full; no overflow.
  - REPLACE when empty: treated as PUSH (count becomes 1, tos=data_in); underflow <= 1; pop_valid=0.
- Error flags:
  - clr_err clears both flags on the next edge.
  - If a new error occurs on the same edge as clr_err, the set wins.
- pop_valid is high for exactly one cycle per accepted pop or replace. Back-to-back pops produce back-to-back pulses.
- No wrap-around: count saturates between 0 and DEPTH. A pointer never indexes outside storage.
- Storage is synchronous-write. tos and nos are cached registers, so no combinational read path drives the outputs.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> count=3, tos=0x33, nos=0x22, empty=0, full=0.
- Pop three times -> pop_data 0x33, 0x22, 0x11 with pop_valid pulsing each cycle; final count=0, tos=0, empty=1, underflow=0.
- From empty, pop -> underflow=1, count=0, pop_valid=0. Then assert clr_err -> underflow=0 next cycle.
- Push 16 values 0x00..0x0F -> full=1, tos=0x0F. Push 0xAA -> overflow=1, tos=0x0F, count=16. Pop -> pop_data=0x0F, tos=0x0E.
- With stack holding 0x05, 0x07: push=pop=1 with data_in=0x99 -> pop_data=0x07, pop_valid=1, tos=0x99, nos=0x05, count=2.
- Push 0x44, 0x55, then assert reset together with push=1 -> count=0, tos=0, overflow=0, underflow=0 (reset dominates).

Source files
------------

// File: rtl/stack_unit_if.sv
// Handshake and status bundle between the CPU control FSM and the operand stack.
interface stack_unit_if #(
  parameter int DATA_W = 8,
  parameter int PTR_W  = 4
);
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic              clr_err;
  logic [DATA_W-1:0] tos;
  logic [DATA_W-1:0] nos;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic [PTR_W:0]    count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, data_in, clr_err,
    input  tos, nos, pop_data, pop_valid, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, data_in, clr_err,
    output tos, nos, pop_data, pop_valid, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/stack_unit.sv
// LIFO operand stack with cached top/next-on-stack registers and sticky error flags.
module stack_unit #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic         clk,
  input  logic         reset,
  stack_unit_if.slave  bus
);
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_PUSH_FULL,
    OP_POP,
    OP_POP_EMPTY,
    OP_REPLACE,
    OP_REPLACE_EMPTY
  } op_e;

  localparam logic [PTR_W:0] CNT_DEPTH = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] tos_q, tos_d, nos_q, nos_d, pop_data_q, pop_data_d;
  logic              pop_valid_q, pop_valid_d;
  logic              ovf_q, udf_q, ovf_set, udf_set;
  logic              empty_q, full_q;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx, top_idx, third_idx;
  op_e               op;

  assign top_idx   = count_q[PTR_W-1:0] - PTR_W'(1);
  assign third_idx = count_q[PTR_W-1:0] - PTR_W'(3);

  always_comb begin
    op = OP_IDLE;
    if (bus.push && !bus.pop)
      op = (count_q == CNT_DEPTH) ? OP_PUSH_FULL : OP_PUSH;
    else if (!bus.push && bus.pop)
      op = (count_q == '0) ? OP_POP_EMPTY : OP_POP;
    else if (bus.push && bus.pop)
      op = (count_q == '0) ? OP_REPLACE_EMPTY : OP_REPLACE;
  end

  always_comb begin
    count_d     = count_q;
    tos_d       = tos_q;
    nos_d       = nos_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = count_q[PTR_W-1:0];
    ovf_set     = 1'b0;
    udf_set     = 1'b0;
    case (op)
      OP_PUSH, OP_REPLACE_EMPTY: begin
        wr_en   = 1'b1;
        count_d = count_q + (PTR_W+1)'(1);
        tos_d   = bus.data_in;
        nos_d   = tos_q;
        udf_set = (op == OP_REPLACE_EMPTY);
      end
      OP_PUSH_FULL: ovf_set = 1'b1;
      OP_POP: begin
        pop_data_d  = tos_q;
        pop_valid_d = 1'b1;
        count_d     = count_q - (PTR_W+1)'(1);
        tos_d       = nos_q;
        // The new nos lives two slots below the old top in storage.
        nos_d       = (count_q >= (PTR_W+1)'(3)) ? mem[third_idx] : '0;
      end
      OP_POP_EMPTY: udf_set = 1'b1;
      OP_REPLACE: begin
        wr_en       = 1'b1;
        wr_idx      = top_idx;
        pop_data_d  = tos_q;
        pop_valid_d = 1'b1;
        tos_d       = bus.data_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en)
      mem[wr_idx] <= bus.data_in;
  end

  // empty/full are taken from the next count so they stay direct flop outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      tos_q       <= '0;
      nos_q       <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      tos_q       <= tos_d;
      nos_q       <= nos_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= (ovf_q && !bus.clr_err) || ovf_set;
      udf_q       <= (udf_q && !bus.clr_err) || udf_set;
      empty_q     <= (count_d == '0);
      full_q      <= (count_d == CNT_DEPTH);
    end
  end

  assign bus.count     = count_q;
  assign bus.tos       = tos_q;
  assign bus.nos       = nos_q;
  assign bus.pop_data  = pop_data_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
endmodule

// File: tb/tb_stack_unit.sv
// Directed-vector bench for stack_unit with hand-computed expectations.
module tb_stack_unit;
  logic clk = 1'b0;
  logic reset;
  int unsigned tests = 0;
  int unsigned failed = 0;

  stack_unit_if #(.DATA_W(8), .PTR_W(4)) bus ();

  stack_unit #(.DATA_W(8), .DEPTH(16), .PTR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one operation for exactly one rising edge, then settle 1 time unit past it.
  task automatic drive(input logic p, input logic q, input logic [7:0] d, input logic c);
    bus.push    = p;
    bus.pop     = q;
    bus.data_in = d;
    bus.clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
    check("rst_count", bus.count, 0);
    check("rst_tos", bus.tos, 0);
    check("rst_nos", bus.nos, 0);
    check("rst_pop_data", bus.pop_data, 0);
    check("rst_pop_valid", bus.pop_valid, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_udf", bus.underflow, 0);

    drive(1, 0, 8'h11, 0);
    check("push1_tos", bus.tos, 8'h11);
    check("push1_nos", bus.nos, 0);
    check("push1_valid", bus.pop_valid, 0);
    drive(1, 0, 8'h22, 0);
    drive(1, 0, 8'h33, 0);
    check("push3_count", bus.count, 3);
    check("push3_tos", bus.tos, 8'h33);
    check("push3_nos", bus.nos, 8'h22);
    check("push3_empty", bus.empty, 0);
    check("push3_full", bus.full, 0);

    drive(0, 1, 8'h00, 0);
    check("pop1_data", bus.pop_data, 8'h33);
    check("pop1_valid", bus.pop_valid, 1);
    check("pop1_tos", bus.tos, 8'h22);
    check("pop1_nos", bus.nos, 8'h11);
    drive(0, 1, 8'h00, 0);
    check("pop2_data", bus.pop_data, 8'h22);
    check("pop2_valid", bus.pop_valid, 1);
    check("pop2_nos", bus.nos, 0);
    drive(0, 1, 8'h00, 0);
    check("pop3_data", bus.pop_data, 8'h11);
    check("pop3_valid", bus.pop_valid, 1);
    check("pop3_count", bus.count, 0);
    check("pop3_tos", bus.tos, 0);
    check("pop3_empty", bus.empty, 1);
    check("pop3_udf", bus.underflow, 0);
    idle();
    check("idle_valid", bus.pop_valid, 0);

    drive(0, 1, 8'h00, 0);
    check("uf_flag", bus.underflow, 1);
    check("uf_count", bus.count, 0);
    check("uf_valid", bus.pop_valid, 0);
    check("uf_pop_data_held", bus.pop_data, 8'h11);
    drive(0, 0, 8'h00, 1);
    check("uf_clr", bus.underflow, 0);
    drive(0, 1, 8'h00, 1);
    check("uf_set_wins", bus.underflow, 1);
    drive(0, 0, 8'h00, 1);
    check("uf_clr2", bus.underflow, 0);

    for (int i = 0; i < 16; i++) drive(1, 0, 8'(i), 0);
    check("fill_full", bus.full, 1);
    check("fill_count", bus.count, 16);
    check("fill_tos", bus.tos, 8'h0F);
    check("fill_nos", bus.nos, 8'h0E);
    drive(1, 0, 8'hAA, 0);
    check("of_flag", bus.overflow, 1);
    check("of_tos", bus.tos, 8'h0F);
    check("of_count", bus.count, 16);
    drive(0, 1, 8'h00, 0);
    check("fpop_data", bus.pop_data, 8'h0F);
    check("fpop_tos", bus.tos, 8'h0E);
    check("fpop_nos", bus.nos, 8'h0D);
    check("fpop_count", bus.count, 15);
    check("fpop_full", bus.full, 0);
    check("fpop_ovf_sticky", bus.overflow, 1);
    drive(1, 0, 8'h0F, 1);
    check("refill_full", bus.full, 1);
    check("ovf_clr", bus.overflow, 0);
    drive(1, 1, 8'h77, 0);
    check("frep_data", bus.pop_data, 8'h0F);
    check("frep_tos", bus.tos, 8'h77);
    check("frep_nos", bus.nos, 8'h0E);
    check("frep_count", bus.count, 16);
    check("frep_no_ovf", bus.overflow, 0);
    drive(1, 0, 8'hBB, 1);
    check("ovf_set_wins", bus.overflow, 1);
    drive(0, 1, 8'h00, 0);
    check("pop_after_rep", bus.pop_data, 8'h77);

    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("rst2_ovf", bus.overflow, 0);
    drive(1, 0, 8'h05, 0);
    drive(1, 0, 8'h07, 0);
    drive(1, 1, 8'h99, 0);
    check("rep_data", bus.pop_data, 8'h07);
    check("rep_valid", bus.pop_valid, 1);
    check("rep_tos", bus.tos, 8'h99);
    check("rep_nos", bus.nos, 8'h05);
    check("rep_count", bus.count, 2);
    drive(0, 1, 8'h00, 0);
    check("rpop1_data", bus.pop_data, 8'h99);
    check("rpop1_tos", bus.tos, 8'h05);
    check("rpop1_nos", bus.nos, 0);
    drive(0, 1, 8'h00, 0);
    check("rpop2_data", bus.pop_data, 8'h05);
    check("rpop2_empty", bus.empty, 1);

    drive(1, 1, 8'h3C, 0);
    check("repe_count", bus.count, 1);
    check("repe_tos", bus.tos, 8'h3C);
    check("repe_udf", bus.underflow, 1);
    check("repe_valid", bus.pop_valid, 0);
    check("repe_pop_data", bus.pop_data, 8'h05);

    drive(1, 0, 8'h44, 0);
    drive(1, 0, 8'h55, 0);
    reset = 1'b1;
    drive(1, 0, 8'h66, 0);
    reset = 1'b0;
    check("rstdom_count", bus.count, 0);
    check("rstdom_tos", bus.tos, 0);
    check("rstdom_nos", bus.nos, 0);
    check("rstdom_ovf", bus.overflow, 0);
    check("rstdom_udf", bus.underflow, 0);
    check("rstdom_empty", bus.empty, 1);
    drive(1, 0, 8'h12, 0);
    check("post_rst_tos", bus.tos, 8'h12);
    check("post_rst_nos", bus.nos, 0);
    check("post_rst_count", bus.count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
